// File: rtl/serial_sub_engine.sv
// Bit-serial WIDTH-bit subtractor (dif = a - b - bin), LSB first, one full-subtractor bit per clock.
// Optional SUB_SIGNED_OVF_EN adds the signed overflow flag; without it ovf is tied to 0.
module serial_sub_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dif,
  output logic             bw,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] dif_q, dif_d;
  logic             borrow_q, borrow_d;
  logic             bw_q, bw_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic x, y, d_bit, brw_nxt, accept, run_last;

  assign x        = a_sh_q[0];
  assign y        = b_sh_q[0];
  assign d_bit    = x ^ y ^ borrow_q;
  assign brw_nxt  = (~x & y) | (~(x ^ y) & borrow_q);
  assign accept   = (state_q == S_IDLE) && in_valid;
  assign run_last = (state_q == S_RUN) && (cnt_q == LAST);

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    dif_d    = dif_q;
    borrow_d = borrow_q;
    bw_d     = bw_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_d    = {d_bit, res_q[WIDTH-1:1]};
        borrow_d = brw_nxt;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Results are latched separately so they survive the next operand load.
          dif_d   = {d_bit, res_q[WIDTH-1:1]};
          bw_d    = brw_nxt;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      dif_q    <= '0;
      borrow_q <= 1'b0;
      bw_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      dif_q    <= dif_d;
      borrow_q <= borrow_d;
      bw_q     <= bw_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign dif       = dif_q;
  assign bw        = bw_q;

`ifdef SUB_SIGNED_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;

  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end
    // d_bit on the last RUN cycle is the result MSB.
    if (run_last) ovf_d = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_ok;
  assign unused_ok = accept ^ run_last;
  assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sub_engine.sv
// Bench for serial_sub_engine: queue-based result/timing model checked every cycle plus directed literals.
module tb_serial_sub_engine;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dif;
  logic         bw;
  logic         ovf;

  serial_sub_engine #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .dif(dif), .bw(bw), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    logic [W-1:0] dif;
    logic         bw;
    logic         ovf;
    int           due;
  } res_t;

  res_t exp_q[$];

  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin, input int due);
    res_t r;
    logic [W:0] full;
    full  = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    r.dif = full[W-1:0];
    r.bw  = full[W];
`ifdef SUB_SIGNED_OVF_EN
    r.ovf = (ma[W-1] != mb[W-1]) && (r.dif[W-1] != ma[W-1]);
`else
    r.ovf = 1'b0;
`endif
    r.due = due;
    return r;
  endfunction

  // Compare process: expectations derived from the pending-result queue only.
  always @(negedge clk) begin
    logic exp_ov, exp_ir;
    if (!rst_n) begin
      exp_q.delete();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
    end else begin
      exp_ir = (exp_q.size() == 0);
      exp_ov = (exp_q.size() != 0) && (cyc >= exp_q[0].due);
      chk("in_ready", in_ready, exp_ir);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        chk("dif", dif, exp_q[0].dif);
        chk("bw", bw, exp_q[0].bw);
        chk("ovf", ovf, exp_q[0].ovf);
        if (out_ready) void'(exp_q.pop_front());
      end
      // Result appears after the accept edge plus WIDTH run edges.
      if (exp_ir && in_valid) exp_q.push_back(model(a, b, bin, cyc + W + 1));
    end
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                       input logic [W-1:0] edif, input logic ebw, input logic eovf_signed);
    int n;
    logic eovf;
`ifdef SUB_SIGNED_OVF_EN
    eovf = eovf_signed;
`else
    eovf = 1'b0;
`endif
    @(posedge clk); #1;
    in_valid = 1'b1; a = ta; b = tb_v; bin = tbin;
    n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    if (n >= 40) timeout("accept_wait");
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    if (n >= 40) timeout("result_wait");
    chk("latency", n, W);
    chk("lit_dif", dif, edif);
    chk("lit_bw", bw, ebw);
    chk("lit_ovf", ovf, eovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, last;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dif", dif, 0);
    chk("reset_bw", bw, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;

    do_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    do_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // Backpressure with new operands offered while DONE.
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_op(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);
    in_valid = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_dif", dif, 8'h22);
      chk("bp_bw", bw, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);

    // Reset three cycles into RUN aborts the operation.
    in_valid = 1'b1; a = 8'hAA; b = 8'h55; bin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_dif", dif, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    // Back-to-back throughput with out_ready held high.
    @(posedge clk); #1;
    last = -1;
    in_valid = 1'b1; a = 8'hC3; b = 8'h3C; bin = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
      if (n >= 40) timeout("thru_wait");
      @(posedge clk); #1;
      acc = cyc;
      if (last >= 0) chk("throughput", acc - last, W + 2);
      last = acc;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    end
    in_valid = 1'b0;
    repeat (W + 6) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
